// File: rtl/sdiv_pkg.sv
// rtl/sdiv_pkg.sv - shared types and helpers for the signed iterative divider
package sdiv_pkg;

  typedef enum logic [1:0] {
    SDIV_IDLE,
    SDIV_RUN,
    SDIV_FIX,
    SDIV_DONE
  } sdiv_state_e;

  // Helpers work on a fixed wide vector; callers sign-extend in and slice out width+1 bits.
  localparam int SDIV_MAX_W          = 127;
  localparam int SDIV_DEFAULT_WIDTH  = 32;
  localparam int SDIV_CNT_W          = $clog2(SDIV_DEFAULT_WIDTH);

  function automatic int sdiv_cnt_width(input int w);
    return $clog2(w);
  endfunction

  function automatic logic [SDIV_MAX_W:0] sdiv_abs(input logic [SDIV_MAX_W:0] v);
    return v[SDIV_MAX_W] ? -v : v;
  endfunction

endpackage

// File: rtl/std_div_step.sv
// rtl/std_div_step.sv - one restoring-division step on unsigned magnitudes
module std_div_step #(
  parameter int width = 32
) (
  input  logic [width:0] rem_i,
  input  logic           bit_i,
  input  logic [width:0] dvs_i,
  output logic [width:0] rem_o,
  output logic           q_o
);

  logic [width:0] shifted;
  logic           unused_rem_msb;

  // The incoming remainder is always below the divisor magnitude (<= 2^(width-1)), so its MSB is zero.
  assign shifted        = {rem_i[width-1:0], bit_i};
  assign unused_rem_msb = rem_i[width];
  assign q_o            = (shifted >= dvs_i);
  assign rem_o          = q_o ? (shifted - dvs_i) : shifted;

endmodule

// File: rtl/std_sdiv_pipe.sv
// rtl/std_sdiv_pipe.sv - multi-cycle signed divider with go/done handshake
module std_sdiv_pipe
  import sdiv_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             done
);

  localparam int CNT_W = sdiv_cnt_width(width);

  sdiv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width:0]   rem_q, rem_d;
  logic [width:0]   dvs_q, dvs_d;
  logic [width-1:0] dvd_q, dvd_d;
  logic [width-1:0] quo_q, quo_d;
  logic [width-1:0] rmd_q, rmd_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             dz_q, dz_d;

  logic [SDIV_MAX_W:0] abs_left, abs_right;
  logic [width:0]      step_rem;
  logic                step_bit;
  logic [width-1:0]    fix_quo, fix_rmd;
  logic                unused_bits;

  assign abs_left  = sdiv_abs({{(SDIV_MAX_W + 1 - width){left[width-1]}}, left});
  assign abs_right = sdiv_abs({{(SDIV_MAX_W + 1 - width){right[width-1]}}, right});
  assign unused_bits = ^{abs_left[SDIV_MAX_W:width+1], abs_right[SDIV_MAX_W:width+1], rem_q[width]};

  std_div_step #(.width(width)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[width-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom.
  assign fix_quo = (neg_a_q ^ neg_b_q) ? -dvd_q : dvd_q;
  assign fix_rmd = neg_a_q ? -rem_q[width-1:0] : rem_q[width-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    unique case (state_q)
      SDIV_IDLE: begin
        if (go) begin
          state_d = SDIV_RUN;
          cnt_d   = CNT_W'(width - 1);
          rem_d   = '0;
          dvd_d   = abs_left[width-1:0];
          dvs_d   = abs_right[width:0];
          neg_a_d = left[width-1];
          neg_b_d = right[width-1];
          dz_d    = (right == '0);
        end
      end
      SDIV_RUN: begin
        if (!go) begin
          state_d = SDIV_IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[width-2:0], step_bit};
          if (cnt_q == '0) state_d = SDIV_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      SDIV_FIX: begin
        if (!go) begin
          state_d = SDIV_IDLE;
        end else begin
          quo_d   = dz_q ? '1 : fix_quo;
          rmd_d   = fix_rmd;
          state_d = SDIV_DONE;
        end
      end
      SDIV_DONE: state_d = SDIV_IDLE;
      default:   state_d = SDIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SDIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
    end
  end

  assign out_quotient  = quo_q;
  assign out_remainder = rmd_q;
  assign done          = (state_q == SDIV_DONE);

endmodule
